// File: rtl/extrema_detector.sv
// Peak/trough detector with hysteresis, minimum inter-event gap, saturating event counters
// and peak-to-peak period measurement over the valid-sample stream.
module extrema_detector #(
    parameter int DATA_W   = 10,
    parameter int CNT_W    = 10,
    parameter int PERIOD_W = 16,
    parameter int HYST     = 8,
    parameter int MIN_GAP  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                sample_valid,
    input  logic [DATA_W-1:0]   sample,
    output logic                peak_pulse,
    output logic                trough_pulse,
    output logic [DATA_W-1:0]   peak_value,
    output logic [DATA_W-1:0]   trough_value,
    output logic [CNT_W-1:0]    num_peaks,
    output logic [CNT_W-1:0]    num_troughs,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    // since_evt only needs to reach MIN_GAP; one spare bit keeps the saturation point above it
    localparam int GAP_W = $clog2(MIN_GAP + 2) + 1;
    localparam logic [DATA_W:0] HYST_X  = (DATA_W+1)'(HYST);
    localparam logic [GAP_W:0]  GAP_REQ = (GAP_W+1)'(MIN_GAP);

    typedef enum logic [1:0] {
        INIT,
        RISING,
        FALLING
    } state_t;

    state_t              state_q, state_d;
    logic                primed_q, primed_d;
    logic [DATA_W-1:0]   run_max_q, run_max_d;
    logic [DATA_W-1:0]   run_min_q, run_min_d;
    logic [GAP_W-1:0]    since_evt_q, since_evt_d;
    logic                evt_seen_q, evt_seen_d;
    logic [PERIOD_W-1:0] since_pk_q, since_pk_d;
    logic                pk_seen_q, pk_seen_d;
    logic                peak_pulse_q, peak_pulse_d;
    logic                trough_pulse_q, trough_pulse_d;
    logic [DATA_W-1:0]   peak_value_q, peak_value_d;
    logic [DATA_W-1:0]   trough_value_q, trough_value_d;
    logic [CNT_W-1:0]    num_peaks_q, num_peaks_d;
    logic [CNT_W-1:0]    num_troughs_q, num_troughs_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_valid_q, period_valid_d;

    logic [DATA_W-1:0]   max_upd, min_upd;
    logic                rise, drop, gap_ok;

    // Widened by one bit so sample+HYST and run_min+HYST cannot wrap
    assign max_upd = (sample > run_max_q) ? sample : run_max_q;
    assign min_upd = (sample < run_min_q) ? sample : run_min_q;
    assign rise    = {1'b0, sample} >= ({1'b0, min_upd} + HYST_X);
    assign drop    = ({1'b0, sample} + HYST_X) <= {1'b0, max_upd};
    assign gap_ok  = !evt_seen_q || (({1'b0, since_evt_q} + (GAP_W+1)'(1)) >= GAP_REQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= INIT;
            primed_q       <= 1'b0;
            run_max_q      <= '0;
            run_min_q      <= '0;
            since_evt_q    <= '0;
            evt_seen_q     <= 1'b0;
            since_pk_q     <= '0;
            pk_seen_q      <= 1'b0;
            peak_pulse_q   <= 1'b0;
            trough_pulse_q <= 1'b0;
            peak_value_q   <= '0;
            trough_value_q <= '0;
            num_peaks_q    <= '0;
            num_troughs_q  <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else if (clear) begin
            state_q        <= INIT;
            primed_q       <= 1'b0;
            run_max_q      <= '0;
            run_min_q      <= '0;
            since_evt_q    <= '0;
            evt_seen_q     <= 1'b0;
            since_pk_q     <= '0;
            pk_seen_q      <= 1'b0;
            peak_pulse_q   <= 1'b0;
            trough_pulse_q <= 1'b0;
            peak_value_q   <= '0;
            trough_value_q <= '0;
            num_peaks_q    <= '0;
            num_troughs_q  <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            primed_q       <= primed_d;
            run_max_q      <= run_max_d;
            run_min_q      <= run_min_d;
            since_evt_q    <= since_evt_d;
            evt_seen_q     <= evt_seen_d;
            since_pk_q     <= since_pk_d;
            pk_seen_q      <= pk_seen_d;
            peak_pulse_q   <= peak_pulse_d;
            trough_pulse_q <= trough_pulse_d;
            peak_value_q   <= peak_value_d;
            trough_value_q <= trough_value_d;
            num_peaks_q    <= num_peaks_d;
            num_troughs_q  <= num_troughs_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        primed_d       = primed_q;
        run_max_d      = run_max_q;
        run_min_d      = run_min_q;
        since_evt_d    = since_evt_q;
        evt_seen_d     = evt_seen_q;
        since_pk_d     = since_pk_q;
        pk_seen_d      = pk_seen_q;
        peak_pulse_d   = 1'b0;
        trough_pulse_d = 1'b0;
        peak_value_d   = peak_value_q;
        trough_value_d = trough_value_q;
        num_peaks_d    = num_peaks_q;
        num_troughs_d  = num_troughs_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;

        if (sample_valid) begin
            since_evt_d = (since_evt_q == '1) ? since_evt_q : since_evt_q + GAP_W'(1);
            since_pk_d  = (since_pk_q == '1) ? since_pk_q : since_pk_q + PERIOD_W'(1);

            unique case (state_q)
                INIT: begin
                    if (!primed_q) begin
                        primed_d  = 1'b1;
                        run_max_d = sample;
                        run_min_d = sample;
                    end else begin
                        run_max_d = max_upd;
                        run_min_d = min_upd;
                        if (rise) begin
                            state_d   = RISING;
                            run_max_d = sample;
                        end else if (drop) begin
                            state_d   = FALLING;
                            run_min_d = sample;
                        end
                    end
                end
                RISING: begin
                    run_max_d = max_upd;
                    if (drop && gap_ok) begin
                        peak_value_d = max_upd;
                        peak_pulse_d = 1'b1;
                        num_peaks_d  = (num_peaks_q == '1) ? num_peaks_q : num_peaks_q + CNT_W'(1);
                        state_d      = FALLING;
                        run_min_d    = sample;
                        since_evt_d  = '0;
                        evt_seen_d   = 1'b1;
                        since_pk_d   = '0;
                        pk_seen_d    = 1'b1;
                        if (pk_seen_q) begin
                            period_d       = (since_pk_q == '1) ? since_pk_q : since_pk_q + PERIOD_W'(1);
                            period_valid_d = 1'b1;
                        end
                    end
                end
                FALLING: begin
                    run_min_d = min_upd;
                    if (rise && gap_ok) begin
                        trough_value_d = min_upd;
                        trough_pulse_d = 1'b1;
                        num_troughs_d  = (num_troughs_q == '1) ? num_troughs_q : num_troughs_q + CNT_W'(1);
                        state_d        = RISING;
                        run_max_d      = sample;
                        since_evt_d    = '0;
                        evt_seen_d     = 1'b1;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    assign peak_pulse   = peak_pulse_q;
    assign trough_pulse = trough_pulse_q;
    assign peak_value   = peak_value_q;
    assign trough_value = trough_value_q;
    assign num_peaks    = num_peaks_q;
    assign num_troughs  = num_troughs_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;

endmodule

// File: tb/tb_extrema_detector.sv
// Bench for extrema_detector: three parameterisations share one stimulus stream and are
// checked against an event-index based reference model plus directed expectations.
module tb_extrema_detector;

    localparam int HYST = 8;
    localparam int GAPS [3] = '{4, 4, 6};
    localparam int CMAX [3] = '{1023, 7, 1023};

    logic       clk = 1'b0;
    logic       reset, clear, sample_valid;
    logic [9:0] sample;

    logic       pp0, tp0, perv0, pp1, tp1, perv1, pp2, tp2, perv2;
    logic [9:0] pv0, tv0, np0, nt0, pv1, tv1, pv2, tv2, np2, nt2;
    logic [2:0] np1, nt1;
    logic [15:0] per0, per1, per2;
    logic [58:0] obs [3];

    int passed = 0;
    int total  = 0;

    // model state: direction 0/+1/-1, absolute indices of last event and last peak
    int idx;
    int m_dir [3], m_primed [3], m_max [3], m_min [3], m_last_evt [3], m_last_pk [3];
    int m_pp [3], m_tp [3], m_pv [3], m_tv [3], m_np [3], m_nt [3], m_per [3], m_perv [3];

    always #5 clk = ~clk;

    extrema_detector d0 (
        .clk(clk), .reset(reset), .clear(clear), .sample_valid(sample_valid), .sample(sample),
        .peak_pulse(pp0), .trough_pulse(tp0), .peak_value(pv0), .trough_value(tv0),
        .num_peaks(np0), .num_troughs(nt0), .period(per0), .period_valid(perv0));

    extrema_detector #(.CNT_W(3)) d1 (
        .clk(clk), .reset(reset), .clear(clear), .sample_valid(sample_valid), .sample(sample),
        .peak_pulse(pp1), .trough_pulse(tp1), .peak_value(pv1), .trough_value(tv1),
        .num_peaks(np1), .num_troughs(nt1), .period(per1), .period_valid(perv1));

    extrema_detector #(.MIN_GAP(6)) d2 (
        .clk(clk), .reset(reset), .clear(clear), .sample_valid(sample_valid), .sample(sample),
        .peak_pulse(pp2), .trough_pulse(tp2), .peak_value(pv2), .trough_value(tv2),
        .num_peaks(np2), .num_troughs(nt2), .period(per2), .period_valid(perv2));

    assign obs[0] = {pp0, tp0, pv0, tv0, np0, nt0, per0, perv0};
    assign obs[1] = {pp1, tp1, pv1, tv1, 7'd0, np1, 7'd0, nt1, per1, perv1};
    assign obs[2] = {pp2, tp2, pv2, tv2, np2, nt2, per2, perv2};

    function automatic logic [58:0] expv(input int k);
        return {1'(m_pp[k]), 1'(m_tp[k]), 10'(m_pv[k]), 10'(m_tv[k]), 10'(m_np[k]),
                10'(m_nt[k]), 16'(m_per[k]), 1'(m_perv[k])};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_dir[k] = 0; m_primed[k] = 0; m_max[k] = 0; m_min[k] = 0;
            m_last_evt[k] = -1; m_last_pk[k] = -1;
            m_pp[k] = 0; m_tp[k] = 0; m_pv[k] = 0; m_tv[k] = 0;
            m_np[k] = 0; m_nt[k] = 0; m_per[k] = 0; m_perv[k] = 0;
        end
    endtask

    task automatic model_step(input int s);
        bit gap_ok;
        for (int k = 0; k < 3; k++) begin
            gap_ok = (m_last_evt[k] < 0) || (idx - m_last_evt[k] >= GAPS[k]);
            if (m_dir[k] == 0) begin
                if (m_primed[k] == 0) begin
                    m_primed[k] = 1; m_max[k] = s; m_min[k] = s;
                end else begin
                    if (s > m_max[k]) m_max[k] = s;
                    if (s < m_min[k]) m_min[k] = s;
                    if (s >= m_min[k] + HYST) begin
                        m_dir[k] = 1; m_max[k] = s;
                    end else if (s + HYST <= m_max[k]) begin
                        m_dir[k] = -1; m_min[k] = s;
                    end
                end
            end else if (m_dir[k] == 1) begin
                if (s > m_max[k]) m_max[k] = s;
                if (s + HYST <= m_max[k] && gap_ok) begin
                    m_pv[k] = m_max[k]; m_pp[k] = 1;
                    if (m_np[k] < CMAX[k]) m_np[k]++;
                    if (m_last_pk[k] >= 0) begin
                        m_per[k] = (idx - m_last_pk[k] > 65535) ? 65535 : idx - m_last_pk[k];
                        m_perv[k] = 1;
                    end
                    m_last_pk[k] = idx; m_last_evt[k] = idx;
                    m_dir[k] = -1; m_min[k] = s;
                end
            end else begin
                if (s < m_min[k]) m_min[k] = s;
                if (s >= m_min[k] + HYST && gap_ok) begin
                    m_tv[k] = m_min[k]; m_tp[k] = 1;
                    if (m_nt[k] < CMAX[k]) m_nt[k]++;
                    m_last_evt[k] = idx;
                    m_dir[k] = 1; m_max[k] = s;
                end
            end
        end
        idx++;
    endtask

    // One clock: drive on the falling edge, advance the model, sample 1 ns after the rising edge
    task automatic cyc(input bit v, input int s, input bit clr);
        @(negedge clk);
        sample_valid = v;
        clear        = clr;
        sample       = v ? 10'(s) : 10'($urandom_range(0, 1023));
        @(posedge clk);
        #1;
        if (clr) model_reset();
        else begin
            for (int k = 0; k < 3; k++) begin m_pp[k] = 0; m_tp[k] = 0; end
            if (v) model_step(s);
        end
        sample_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; sample_valid = 1'b0; sample = '0;
        idx = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== expv(k)) $display("FAIL reset_state inst%0d got=%h want=%h", k, obs[k], expv(k));
            else passed++;
        end
        @(negedge clk) reset = 1'b0;
        for (int v = 0; v <= 100; v += 20) cyc(1'b1, v, 1'b0);
        for (int v = 80; v >= 40; v -= 20) begin
            cyc(1'b1, v, 1'b0);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs[k] !== expv(k)) $display("FAIL pre_reset inst%0d got=%h want=%h", k, obs[k], expv(k));
                else passed++;
            end
        end
        @(negedge clk) reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== 59'd0) $display("FAIL async_reset inst%0d got=%h want=0", k, obs[k]);
            else passed++;
        end
        model_reset();
        @(negedge clk) reset = 1'b0;
        cyc(1'b1, 500, 1'b0);
        cyc(1'b1, 505, 1'b0);
        cyc(1'b1, 515, 1'b0);
        cyc(1'b1, 505, 1'b0);
        total++;
        if (pp0 !== 1'b1 || pv0 !== 10'd515 || tp0 !== 1'b0)
            $display("FAIL reinit_peak got pp=%b pv=%0d tp=%b want pp=1 pv=515 tp=0", pp0, pv0, tp0);
        else passed++;
    endtask

    task automatic test_ramp();
        cyc(1'b1, 0, 1'b1);
        for (int v = 0; v <= 100; v += 10) cyc(1'b1, v, 1'b0);
        cyc(1'b1, 90, 1'b0);
        total++;
        if (pp0 !== 1'b1 || pv0 !== 10'd100 || np0 !== 10'd1)
            $display("FAIL ramp_peak got pp=%b pv=%0d np=%0d want 1/100/1", pp0, pv0, np0);
        else passed++;
        for (int v = 80; v >= 0; v -= 10) cyc(1'b1, v, 1'b0);
        cyc(1'b1, 10, 1'b0);
        total++;
        if (tp0 !== 1'b1 || tv0 !== 10'd0 || nt0 !== 10'd1)
            $display("FAIL ramp_trough got tp=%b tv=%0d nt=%0d want 1/0/1", tp0, tv0, nt0);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== expv(k)) $display("FAIL ramp_model inst%0d got=%h want=%h", k, obs[k], expv(k));
            else passed++;
        end
    endtask

    task automatic test_flat();
        int pulses = 0;
        cyc(1'b1, 0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, (i % 2 == 0) ? 50 : 55, 1'b0);
            if (pp0 || tp0) pulses++;
        end
        total++;
        if (pulses != 0 || np0 !== 10'd0 || nt0 !== 10'd0)
            $display("FAIL flat got pulses=%0d np=%0d nt=%0d want 0/0/0", pulses, np0, nt0);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== expv(k)) $display("FAIL flat_model inst%0d got=%h want=%h", k, obs[k], expv(k));
            else passed++;
        end
    endtask

    task automatic test_period();
        int peaks = 0;
        int wave [$];
        cyc(1'b1, 0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            for (int v = 0; v <= 100; v += 10) wave.push_back(v);
            if (c < 2) for (int v = 90; v >= 10; v -= 10) wave.push_back(v);
        end
        wave.push_back(90);
        foreach (wave[i]) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) cyc(1'b0, 0, 1'b0);
            cyc(1'b1, wave[i], 1'b0);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs[k] !== expv(k)) $display("FAIL period_model inst%0d got=%h want=%h", k, obs[k], expv(k));
                else passed++;
            end
            if (pp0) begin
                peaks++;
                if (peaks >= 2) begin
                    total++;
                    if (per0 !== 16'd20 || perv0 !== 1'b1)
                        $display("FAIL period got per=%0d pv=%b want 20/1", per0, perv0);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_saturate();
        int pulses = 0;
        int tri_w [8] = '{0, 25, 50, 75, 100, 75, 50, 25};
        cyc(1'b1, 0, 1'b1);
        for (int c = 0; c < 9; c++) begin
            for (int j = 0; j < 8; j++) begin
                cyc(1'b1, tri_w[j], 1'b0);
                if (pp1) pulses++;
                for (int k = 0; k < 3; k++) begin
                    total++;
                    if (obs[k] !== expv(k)) $display("FAIL sat_model inst%0d got=%h want=%h", k, obs[k], expv(k));
                    else passed++;
                end
            end
        end
        total++;
        if (pulses != 9 || np1 !== 3'd7)
            $display("FAIL saturate got pulses=%0d np=%0d want 9/7", pulses, np1);
        else passed++;
    endtask

    task automatic test_gap();
        int seq [$] = '{0, 20, 0, 20, 0, 20, 0, 20, 0, 0, 0, 0, 0, 0,
                        1023, 1023, 1023, 1023, 1023, 1023, 1015};
        cyc(1'b1, 0, 1'b1);
        foreach (seq[i]) begin
            cyc(1'b1, seq[i], 1'b0);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs[k] !== expv(k)) $display("FAIL gap_model inst%0d got=%h want=%h", k, obs[k], expv(k));
                else passed++;
            end
        end
        total++;
        if (pp2 !== 1'b1 || pv2 !== 10'd1023 || np2 !== 10'd2)
            $display("FAIL gap_peak got pp=%b pv=%0d np=%0d want 1/1023/2", pp2, pv2, np2);
        else passed++;
        cyc(1'b1, 300, 1'b1);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== 59'd0) $display("FAIL clear_wins inst%0d got=%h want=0", k, obs[k]);
            else passed++;
        end
        cyc(1'b1, 300, 1'b0);
        cyc(1'b1, 320, 1'b0);
        cyc(1'b1, 310, 1'b0);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== expv(k)) $display("FAIL post_clear inst%0d got=%h want=%h", k, obs[k], expv(k));
            else passed++;
        end
    endtask

    task automatic test_random();
        int s = 512;
        cyc(1'b1, 0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            s = s + $urandom_range(0, 60) - 30;
            if (s < 0) s = 0;
            if (s > 1023) s = 1023;
            cyc($urandom_range(0, 3) != 0, s, $urandom_range(0, 199) == 0);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs[k] !== expv(k)) $display("FAIL random inst%0d cyc%0d got=%h want=%h", k, i, obs[k], expv(k));
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_flat();
        test_period();
        test_saturate();
        test_gap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
